// File: rtl/alu_pkg.sv
// Shared op-code and FSM definitions for the sequential ALU and the MIPS control unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1110;
    localparam logic [3:0] ALU_MFLO  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_t;

    // True for the op codes that run on the iterative engine.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one bit per cycle.
// done is asserted during the last iteration cycle; hi_n/lo_n then carry the final values
// so the top can commit them on that same edge.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // acc holds the partial product high half / partial remainder,
    // mq holds the multiplier being shifted out / dividend shifting into quotient.
    logic [WIDTH-1:0] acc_reg, mq_reg, opb_reg;
    logic [WIDTH-1:0] acc_next, mq_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg, is_div_reg;
    logic [WIDTH:0]   sum, shifted, diff;

    // One iteration step of whichever operation is running.
    always_comb begin
        sum      = {1'b0, acc_reg} + {1'b0, opb_reg};
        shifted  = {acc_reg, mq_reg[WIDTH-1]};
        diff     = shifted - {1'b0, opb_reg};
        acc_next = acc_reg;
        mq_next  = mq_reg;
        if (is_div_reg) begin
            // A clear borrow bit means the trial subtraction fits: quotient bit is 1.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                mq_next  = {mq_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                mq_next  = {mq_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mq_reg[0]) begin
                {acc_next, mq_next} = {sum, mq_reg[WIDTH-1:1]};
            end else begin
                {acc_next, mq_next} = {1'b0, acc_reg, mq_reg[WIDTH-1:1]};
            end
        end
    end

    assign done = active_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign hi_n = acc_next;
    assign lo_n = mq_next;

    // Operand capture on start, then WIDTH iteration cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mq_reg     <= '0;
            opb_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            is_div_reg <= 1'b0;
        end else if (start) begin
            acc_reg    <= '0;
            mq_reg     <= a;
            opb_reg    <= b;
            cnt_reg    <= '0;
            active_reg <= 1'b1;
            is_div_reg <= op_div;
        end else if (active_reg) begin
            acc_reg <= acc_next;
            mq_reg  <= mq_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_32bit.sv
// Sequential MIPS ALU: single-cycle logic/arithmetic ops plus iterative MULTU/DIVU into HI/LO,
// with valid/ready on both sides and a one-entry output register.
module alu_seq_32bit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit HAS_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    alu_state_t       state_reg, state_next;
    logic             out_valid_reg, zero_reg;
    logic [WIDTH-1:0] result_reg, alu_res;
    logic             fire, op_muldiv, md_done;
    logic [WIDTH-1:0] md_hi_n, md_lo_n, hi_q, lo_q;

    assign fire      = in_valid && in_ready;
    assign op_muldiv = HAS_MULDIV && is_muldiv(alu_ctrl);

    generate
        if (HAS_MULDIV) begin : g_muldiv
            logic [WIDTH-1:0] hi_reg, lo_reg;

            alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (fire && op_muldiv),
                .op_div (alu_ctrl == ALU_DIVU),
                .a      (in1),
                .b      (in2),
                .done   (md_done),
                .hi_n   (md_hi_n),
                .lo_n   (md_lo_n)
            );

            // HI/LO change only when an iterative op completes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hi_reg <= '0;
                    lo_reg <= '0;
                end else if (md_done) begin
                    hi_reg <= md_hi_n;
                    lo_reg <= md_lo_n;
                end
            end

            assign hi_q = hi_reg;
            assign lo_q = lo_reg;
        end else begin : g_no_muldiv
            assign md_done = 1'b0;
            assign md_hi_n = '0;
            assign md_lo_n = '0;
            assign hi_q    = '0;
            assign lo_q    = '0;
        end
    endgenerate

    // Single-cycle datapath; MFHI/MFLO read the already-committed HI/LO.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND:  alu_res = in1 & in2;
            ALU_OR:   alu_res = in1 | in2;
            ALU_ADD:  alu_res = in1 + in2;
            ALU_SUB:  alu_res = in1 - in2;
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_NOR:  alu_res = ~(in1 | in2);
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // FSM next state: leave IDLE on an accepted MULTU/DIVU, return when the engine finishes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (fire && op_muldiv)
                         state_next = (alu_ctrl == ALU_DIVU) ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (md_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the output slot is free or draining.
    always_comb begin
        busy     = (state_reg != ST_IDLE);
        in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    end

    // One-entry output register: iterative completion, single-cycle load, or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
        end else if (md_done) begin
            out_valid_reg <= 1'b1;
            result_reg    <= md_lo_n;
            zero_reg      <= (md_lo_n == '0);
        end else if (fire) begin
            // An iterative op leaves the slot empty until it completes.
            out_valid_reg <= !op_muldiv;
            if (!op_muldiv) begin
                result_reg <= alu_res;
                zero_reg   <= (alu_res == '0);
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_seq_32bit.sv
// Directed bench for alu_seq_32bit: table of single ops / MULTU / DIVU plus reset,
// backpressure and WIDTH=8 sequences.
module tb_alu_seq_32bit;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  alu_ctrl;
    logic [31:0] in1, in2, result, hi, lo;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, busy8;
    logic [3:0]  alu_ctrl8;
    logic [7:0]  in1_8, in2_8, result8, hi8, lo8;

    alu_seq_32bit #(.WIDTH(32), .HAS_MULDIV(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .in1(in1), .in2(in2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy),
        .hi(hi), .lo(lo)
    );

    alu_seq_32bit #(.WIDTH(8), .HAS_MULDIV(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_ctrl(alu_ctrl8), .in1(in1_8), .in2(in2_8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .zero(zero8), .busy(busy8),
        .hi(hi8), .lo(lo8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        int          exp_lat;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request, wait for acceptance, then count edges until out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = op; in1 = a; in2 = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt;

        vecs[0]  = '{"add_wrap",  ALU_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1,  0,  32'h0, 32'h0};
        vecs[1]  = '{"sub_neg",   ALU_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1,  0,  32'h0, 32'h0};
        vecs[2]  = '{"sltu",      ALU_SLTU,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1,  0,  32'h0, 32'h0};
        vecs[3]  = '{"slt",       ALU_SLT,   32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1,  0,  32'h0, 32'h0};
        vecs[4]  = '{"nor",       ALU_NOR,   32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1,  0,  32'h0, 32'h0};
        vecs[5]  = '{"and",       ALU_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1,  0,  32'h0, 32'h0};
        vecs[6]  = '{"or",        ALU_OR,    32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1,  0,  32'h0, 32'h0};
        vecs[7]  = '{"multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 33, 32, 32'hFFFF_FFFE, 32'h1};
        vecs[8]  = '{"mfhi_mul",  ALU_MFHI,  32'h0,         32'h0,         32'hFFFF_FFFE, 1'b0, 1,  0,  32'hFFFF_FFFE, 32'h1};
        vecs[9]  = '{"mflo_mul",  ALU_MFLO,  32'h0,         32'h0,         32'h1,         1'b0, 1,  0,  32'hFFFF_FFFE, 32'h1};
        vecs[10] = '{"divu_100_7",ALU_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 33, 32, 32'd2, 32'd14};
        vecs[11] = '{"mfhi_div",  ALU_MFHI,  32'h0,         32'h0,         32'd2,         1'b0, 1,  0,  32'd2, 32'd14};
        vecs[12] = '{"divu_by0",  ALU_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 33, 32, 32'd9, 32'hFFFF_FFFF};
        vecs[13] = '{"mfhi_div0", ALU_MFHI,  32'h0,         32'h0,         32'd9,         1'b0, 1,  0,  32'd9, 32'hFFFF_FFFF};
        vecs[14] = '{"undef_0101",4'b0101,   32'd12,        32'd34,        32'h0,         1'b1, 1,  0,  32'd9, 32'hFFFF_FFFF};
        vecs[15] = '{"mflo_div0", ALU_MFLO,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1,  0,  32'd9, 32'hFFFF_FFFF};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_ctrl = 4'd0; in1 = '0; in2 = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; alu_ctrl8 = 4'd0; in1_8 = '0; in2_8 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a MULTU aborts it with no HI/LO write
        in_valid = 1'b1; alu_ctrl = ALU_MULTU; in1 = 32'd7; in2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("midmul_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("postrst_lo", lo, 32'd0);
        check("postrst_hi", hi, 32'd0);

        // Table-driven ops
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, bcnt);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_result"}, result, vecs[i].exp_res);
            check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
            check({vecs[i].name, "_busy_cycles"}, 32'(bcnt), 32'(vecs[i].exp_busy));
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            $display("[TB] op %s ctrl=%b a=0x%08h b=0x%08h -> result=0x%08h zero=%0b lat=%0d hi=0x%08h lo=0x%08h",
                     vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, result, zero, lat, hi, lo);
        end

        // Backpressure: ADD result held while out_ready=0, pending OR accepted without bubble
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; alu_ctrl = ALU_ADD; in1 = 32'd3; in2 = 32'd4;
        @(posedge clk);
        @(negedge clk);
        alu_ctrl = ALU_OR; in1 = 32'h0000_00F0; in2 = 32'h0000_000F;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_result", result, 32'd7);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b2b_result", result, 32'h0000_00FF);
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        $display("[TB] backpressure ADD 3+4 held, OR 0xF0|0x0F -> 0x%08h", 32'h0000_00FF);

        // WIDTH=8 regression: 200*200 = 0x9C40
        in_valid8 = 1'b1; alu_ctrl8 = ALU_MULTU; in1_8 = 8'd200; in2_8 = 8'd200;
        check("w8_in_ready", {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("w8_latency", 32'(lat), 32'd9);
        check("w8_hi", {24'd0, hi8}, 32'h9C);
        check("w8_lo", {24'd0, lo8}, 32'h40);
        check("w8_result", {24'd0, result8}, 32'h40);
        $display("[TB] W8 MULTU 200*200 -> hi=0x%02h lo=0x%02h lat=%0d", hi8, lo8, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
